// File: rtl/tmr_sched_pkg.sv
// Shared definitions for the DTMR replica scheduler: default tuning constants,
// FSM state encoding and small replica-mask helpers.
package tmr_sched_pkg;

  localparam logic [3:0] ERR_HI    = 4'd8;
  localparam logic [3:0] ERR_LO    = 4'd4;
  localparam int         WARM_CYC  = 4;
  localparam int         HOLD_CYC  = 16;
  localparam int         FAULT_MAX = 3;

  typedef enum logic [1:0] {
    SIMPLEX = 2'd0,
    WARMUP  = 2'd1,
    TMR     = 2'd2
  } fsm_e;

  // Plain-vector aliases of the enum so the FSM register stays a logic vector.
  localparam logic [1:0] ST_SIMPLEX = SIMPLEX;
  localparam logic [1:0] ST_WARMUP  = WARMUP;
  localparam logic [1:0] ST_TMR     = TMR;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  // Next healthy replica after p, searching p+1 then p+2 (mod 3).
  // With no other healthy replica the index is left where it is.
  function automatic logic [1:0] next_healthy(input logic [1:0] p, input logic [2:0] mask);
    logic [1:0] p1;
    logic [1:0] p2;
    p1 = (p  == 2'd2) ? 2'd0 : p  + 2'd1;
    p2 = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
    if (mask[p1])      return p1;
    else if (mask[p2]) return p2;
    else               return p;
  endfunction

endpackage

// File: rtl/tmr_sched_if.sv
// Control/status bundle between the scheduler and the replica/voter datapath.
interface tmr_sched_if;
  logic [3:0] err_rate;
  logic       f1;
  logic       f2;
  logic       b1;
  logic       b2;
  logic [2:0] fault;
  logic [2:0] en;
  logic       state;
  logic [1:0] primary;
  logic [2:0] retired;
  logic       degraded;
  logic       fail;
  logic       unc;

  modport master (
    output err_rate, f1, f2, b1, b2, fault,
    input  en, state, primary, retired, degraded, fail, unc
  );

  modport slave (
    input  err_rate, f1, f2, b1, b2, fault,
    output en, state, primary, retired, degraded, fail, unc
  );
endinterface

// File: rtl/tmr_fault_track.sv
// Per-replica voter fault counters, sticky retirement, uncorrectable-vote
// pulse and primary rotation. Exposes next-state retirement/primary so the
// scheduler can react in the same update.
module tmr_fault_track
  import tmr_sched_pkg::*;
#(
  parameter int FAULT_LIMIT = tmr_sched_pkg::FAULT_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tmr_active,
  input  logic [2:0] fault,
  output logic [2:0] retired_q,
  output logic [2:0] retired_d,
  output logic [1:0] primary_q,
  output logic [1:0] primary_d,
  output logic       unc_q
);

  localparam int              CNT_W   = $clog2(FAULT_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FAULT_LIMIT);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  logic [2:0][CNT_W-1:0] cnt_q;
  logic [2:0][CNT_W-1:0] cnt_d;
  logic [2:0][CNT_W-1:0] cnt_inc;
  logic [2:0]            fault_eff;
  logic [2:0]            hit;
  logic                  single;
  logic                  multi;
  logic                  unc_d;

  // Already-retired replicas are disabled, so their flags carry no information.
  assign fault_eff = fault & ~retired_q;
  assign single    = tmr_active && (popcount3(fault_eff) == 2'd1);
  assign multi     = tmr_active && (popcount3(fault_eff) > 2'd1);

  for (genvar gi = 0; gi < 3; gi++) begin : g_rep
    assign cnt_inc[gi] = (cnt_q[gi] == CNT_SAT) ? cnt_q[gi] : cnt_q[gi] + 1'b1;
    assign hit[gi]     = single && fault_eff[gi] && (cnt_inc[gi] >= CNT_MAX);
  end

  // Counter/retire/rotation next state; a multi-bit vote freezes the counters.
  always_comb begin
    cnt_d     = cnt_q;
    retired_d = retired_q | hit;
    unc_d     = multi;
    if (!multi) begin
      for (int i = 0; i < 3; i++) begin
        cnt_d[i] = (single && fault_eff[i] && !hit[i]) ? cnt_inc[i] : '0;
      end
    end
    primary_d = retired_d[primary_q] ? next_healthy(primary_q, ~retired_d) : primary_q;
  end

  // Tracker state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      retired_q <= 3'b000;
      primary_q <= 2'd0;
      unc_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
      primary_q <= primary_d;
      unc_q     <= unc_d;
    end
  end

endmodule

// File: rtl/tmr_sched.sv
// Simplex/TMR mode scheduler for the three PCC replicas: demand hysteresis,
// warm-up before voting, and replica enable / voter mode generation.
module tmr_sched #(
  parameter logic [3:0] ERR_HI    = tmr_sched_pkg::ERR_HI,
  parameter logic [3:0] ERR_LO    = tmr_sched_pkg::ERR_LO,
  parameter int         WARM_CYC  = tmr_sched_pkg::WARM_CYC,
  parameter int         HOLD_CYC  = tmr_sched_pkg::HOLD_CYC,
  parameter int         FAULT_MAX = tmr_sched_pkg::FAULT_MAX
) (
  input  logic        clk,
  input  logic        rst,
  tmr_sched_if.slave  bus
);
  import tmr_sched_pkg::*;

  localparam int              WARM_W    = $clog2(WARM_CYC + 1);
  localparam int              HOLD_W    = $clog2(HOLD_CYC + 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARM_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  logic [1:0]        fsm_q, fsm_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [2:0]        en_q, en_d;
  logic              state_q, state_d;
  logic              degraded_q, degraded_d;
  logic              fail_q, fail_d;

  logic [2:0] retired_q, retired_d, healthy_d;
  logic [1:0] primary_q, primary_d;
  logic       unc_q;
  logic       sensor, hi, lo, two_ok;

  assign sensor    = bus.f1 | bus.f2 | bus.b1 | bus.b2;
  assign hi        = (bus.err_rate >= ERR_HI) | sensor;
  assign lo        = (bus.err_rate <= ERR_LO) & ~sensor;
  assign healthy_d = ~retired_d;
  assign two_ok    = popcount3(healthy_d) >= 2'd2;

  tmr_fault_track #(.FAULT_LIMIT(FAULT_MAX)) u_fault (
    .clk        (clk),
    .rst        (rst),
    .tmr_active (fsm_q == ST_TMR),
    .fault      (bus.fault),
    .retired_q  (retired_q),
    .retired_d  (retired_d),
    .primary_q  (primary_q),
    .primary_d  (primary_d),
    .unc_q      (unc_q)
  );

  // Mode FSM; uses post-retirement health so a retirement wins over a mode change.
  always_comb begin
    fsm_d  = fsm_q;
    warm_d = warm_q;
    hold_d = '0;
    case (fsm_q)
      ST_SIMPLEX: begin
        if (hi && two_ok) begin
          fsm_d  = ST_WARMUP;
          warm_d = '0;
        end
      end
      ST_WARMUP: begin
        if (!two_ok)                fsm_d = ST_SIMPLEX;
        else if (warm_q == WARM_LAST) fsm_d = ST_TMR;
        else                        warm_d = warm_q + 1'b1;
      end
      ST_TMR: begin
        if (!two_ok) begin
          fsm_d = ST_SIMPLEX;
        end else if (lo) begin
          if (hold_q == HOLD_LAST) fsm_d = ST_SIMPLEX;
          else                     hold_d = hold_q + 1'b1;
        end
      end
      default: fsm_d = ST_SIMPLEX;
    endcase
  end

  // Output decode from next state so every output is a plain register.
  always_comb begin
    fail_d     = (healthy_d == 3'b000);
    degraded_d = popcount3(healthy_d) < 2'd2;
    state_d    = (fsm_d == ST_TMR) && !fail_d;
    if (fail_d)                   en_d = 3'b000;
    else if (fsm_d == ST_SIMPLEX) en_d = 3'b001 << primary_d;
    else                          en_d = healthy_d;
  end

  // Scheduler state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= ST_SIMPLEX;
      warm_q     <= '0;
      hold_q     <= '0;
      en_q       <= 3'b001;
      state_q    <= 1'b0;
      degraded_q <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      warm_q     <= warm_d;
      hold_q     <= hold_d;
      en_q       <= en_d;
      state_q    <= state_d;
      degraded_q <= degraded_d;
      fail_q     <= fail_d;
    end
  end

  assign bus.en       = en_q;
  assign bus.state    = state_q;
  assign bus.primary  = primary_q;
  assign bus.retired  = retired_q;
  assign bus.degraded = degraded_q;
  assign bus.fail     = fail_q;
  assign bus.unc      = unc_q;

endmodule

// File: tb/tb_tmr_sched.sv
// Directed bench for tmr_sched: mode hysteresis, warm-up, fault retirement,
// primary rotation, degraded mode and mid-operation reset.
module tb_tmr_sched;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  tmr_sched_if bus ();

  tmr_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] en, input logic state,
                         input logic [1:0] primary, input logic [2:0] retired,
                         input logic degraded, input logic fail, input logic unc);
    chk({tag, ".en"},       {1'b0, bus.en},      {1'b0, en});
    chk({tag, ".state"},    {3'b0, bus.state},   {3'b0, state});
    chk({tag, ".primary"},  {2'b0, bus.primary}, {2'b0, primary});
    chk({tag, ".retired"},  {1'b0, bus.retired}, {1'b0, retired});
    chk({tag, ".degraded"}, {3'b0, bus.degraded},{3'b0, degraded});
    chk({tag, ".fail"},     {3'b0, bus.fail},    {3'b0, fail});
    chk({tag, ".unc"},      {3'b0, bus.unc},     {3'b0, unc});
    $display("step %-14s en=%b state=%b primary=%0d retired=%b degraded=%b fail=%b unc=%b",
             tag, bus.en, bus.state, bus.primary, bus.retired, bus.degraded, bus.fail, bus.unc);
  endtask

  initial begin
    rst = 1'b1;
    bus.err_rate = 4'd0;
    bus.f1 = 1'b0; bus.f2 = 1'b0; bus.b1 = 1'b0; bus.b2 = 1'b0;
    bus.fault = 3'b000;
    step(2);
    chk_all("reset", 3'b001, 0, 2'd0, 3'b000, 0, 0, 0);

    // Low demand keeps simplex.
    rst = 1'b0;
    bus.err_rate = 4'd2;
    step(10);
    chk_all("idle", 3'b001, 0, 2'd0, 3'b000, 0, 0, 0);

    // High error rate: warm-up for 4 cycles, then voting.
    bus.err_rate = 4'd9;
    step(1);
    chk_all("warm_c1", 3'b111, 0, 2'd0, 3'b000, 0, 0, 0);
    step(3);
    chk_all("warm_c4", 3'b111, 0, 2'd0, 3'b000, 0, 0, 0);
    step(1);
    chk_all("tmr_c5", 3'b111, 1, 2'd0, 3'b000, 0, 0, 0);

    // Hold: 8 low cycles, one mid-band glitch, then a fresh 16-cycle count.
    bus.err_rate = 4'd3;
    step(8);
    bus.err_rate = 4'd6;
    step(1);
    bus.err_rate = 4'd3;
    step(15);
    chk_all("hold_15", 3'b111, 1, 2'd0, 3'b000, 0, 0, 0);
    step(1);
    chk_all("hold_exit", 3'b001, 0, 2'd0, 3'b000, 0, 0, 0);

    // Reset in the middle of warm-up.
    bus.err_rate = 4'd9;
    step(2);
    chk_all("warm_again", 3'b111, 0, 2'd0, 3'b000, 0, 0, 0);
    rst = 1'b1;
    step(1);
    chk_all("rst_warm", 3'b001, 0, 2'd0, 3'b000, 0, 0, 0);
    rst = 1'b0;
    step(1);
    chk_all("rewarm", 3'b111, 0, 2'd0, 3'b000, 0, 0, 0);
    step(4);
    chk_all("retmr", 3'b111, 1, 2'd0, 3'b000, 0, 0, 0);

    // Replica 1 faults twice, a clean vote clears the count, twice more.
    bus.fault = 3'b010; step(2);
    bus.fault = 3'b000; step(1);
    bus.fault = 3'b010; step(2);
    chk_all("no_retire", 3'b111, 1, 2'd0, 3'b000, 0, 0, 0);
    // Double disagreement: unc pulse, counters frozen (replica 1 stays at 2).
    bus.fault = 3'b011; step(1);
    chk_all("unc_pulse", 3'b111, 1, 2'd0, 3'b000, 0, 0, 1);
    bus.fault = 3'b010; step(1);
    chk_all("retire1", 3'b101, 1, 2'd0, 3'b010, 0, 0, 0);

    // Replica 0 (primary) retires: one healthy left, primary rotates to 2.
    bus.fault = 3'b001; step(2);
    chk_all("r0_pending", 3'b101, 1, 2'd0, 3'b010, 0, 0, 0);
    step(1);
    chk_all("retire011", 3'b100, 0, 2'd2, 3'b011, 1, 0, 0);
    bus.fault = 3'b000;
    step(3);
    chk_all("degr_hold", 3'b100, 0, 2'd2, 3'b011, 1, 0, 0);

    // Reset clears retirement.
    rst = 1'b1;
    step(1);
    chk_all("rst_retired", 3'b001, 0, 2'd0, 3'b000, 0, 0, 0);
    rst = 1'b0;

    // Second run: retire replica 0 then replica 2.
    step(5);
    chk_all("run2_tmr", 3'b111, 1, 2'd0, 3'b000, 0, 0, 0);
    bus.fault = 3'b001; step(3);
    chk_all("retire0", 3'b110, 1, 2'd1, 3'b001, 0, 0, 0);
    bus.fault = 3'b100; step(3);
    chk_all("retire2", 3'b010, 0, 2'd1, 3'b101, 1, 0, 0);
    bus.fault = 3'b000;
    bus.err_rate = 4'd2;
    bus.f1 = 1'b1;
    step(8);
    chk_all("degr_f1", 3'b010, 0, 2'd1, 3'b101, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
